add_rr_sched: RTL and testbench
===============================

Name: add_rr_sched

Overview:
- Round-robin scheduler that shares one registered DW-bit adder between NREQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The block arbitrates, captures the winner's operands and computes the sum.
- It returns the sum tagged with the requester id over a valid/ready result port.
- It sits in front of the shared adder datapath, so only one addition is in flight at a time.

Parameters:
- NREQ, 4, number of requesters (>=2).
- DW, 3, operand width in bits; the sum is DW+1 bits.
- IDW, $clog2(NREQ), width of the requester id (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_vld  input  NREQ  per-requester request valid.
- req_a  input  NREQ*DW  packed operand A; requester i uses bits [i*DW +: DW].
- req_b  input  NREQ*DW  packed operand B, same packing as req_a.
- req_rdy  output  NREQ  one-hot accept; the handshake completes in the cycle req_vld[i] & req_rdy[i].
- res_vld  output  1  result valid.
- res_rdy  input  1  result consumer ready.
- res_sum  output  DW+1  sum of the accepted operands.
- res_id  output  IDW  index of the requester that owns res_sum.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, rr_ptr=0, res_vld=0, res_sum=0, res_id=0, busy=0.
  - Operand registers are cleared.
  - req_rdy is forced to 0 while rst_n is low.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - Winner = first i with req_vld[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - If a winner exists: req_rdy[winner]=1 combinationally in that same cycle; all other req_rdy bits are 0.
  - On the edge: latch req_a/req_b of the winner, latch winner into res_id, set rr_ptr=(winner+1) mod NREQ, go to EXEC.
  - If no req_vld: stay in IDLE, req_rdy=0.
- EXEC:
  - res_sum <= zero-extended a + zero-extended b, full DW+1 bits, never overflows (max 2*(2^DW-1)).
  - Go to RESP; res_vld <= 1.
- RESP:
  - res_vld=1; res_sum and res_id are held stable.
  - If res_rdy=1: res_vld <= 0, go to IDLE.
  - If res_rdy=0: stay in RESP.
  - The result is accepted in the same cycle res_vld first rises if res_rdy is already high.
- req_rdy is 0 in EXEC and RESP; no new request is accepted until the FSM is back in IDLE.
- Latency: accept in cycle T, res_vld=1 in cycle T+2.
- Minimum spacing between accepts is 3 cycles (accept, EXEC, RESP with res_rdy=1).
- Operands need only be valid in the handshake cycle; later changes on req_a/req_b have no effect.
- A requester may drop req_vld before being granted; no state is affected.
- rr_ptr wraps from NREQ-1 to 0. It updates only on an accept, never on idle cycles.
- Reset asserted mid-operation (EXEC or RESP) aborts the transaction: no result is produced and rr_ptr returns to 0.
- X on req_a/req_b of non-winning requesters must not propagate to outputs.

Test Plan:
- Single request:
  - Stimulus: after reset, req_vld=4'b0100, operand pair a=5, b=6, res_rdy=1.
  - Response: req_rdy=4'b0100 in T; res_vld=1 in T+2 with res_sum=11, res_id=2; busy low again at T+3.
- Full contention:
  - Stimulus: req_vld=4'b1111 held, res_rdy=1.
  - Response: grant order 0,1,2,3,0,1, one accept every 3 cycles; each res_id matches its grant.
- Width boundary:
  - Stimulus: a=7, b=7.
  - Response: res_sum=14 (5'b01110 for DW=4 sanity run; 4'b1110 default); a=0, b=0 gives 0.
- Backpressure:
  - Stimulus: res_rdy=0 for 5 cycles while in RESP, other req_vld high.
  - Response: res_vld, res_sum and res_id stay stable; req_rdy=0 throughout; after res_rdy=1, IDLE on the next cycle and the next grant follows.
- Round-robin wrap:
  - Stimulus: only req_vld[1] and req_vld[3] high continuously.
  - Response: grants 1,3,1,3; after granting 3, rr_ptr wraps to 0 and 1 still wins.
- Reset mid-EXEC:
  - Stimulus: assert rst_n=0 one cycle after an accept of requester 2.
  - Response: immediately res_vld=0, res_sum=0, busy=0; no result is ever delivered; with req_vld=4'b1111 after release, requester 0 is granted first.

Source files
------------

// File: rtl/add_rr_sched.sv
// Round-robin front end for a single shared registered adder.
// One operand pair is accepted at a time; the sum is returned with the
// owning requester id and held until the consumer takes it.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | searching for the next requester from rr_ptr; grant is same-cycle
// EXEC  | operands captured, the sum is being registered
// RESP  | result presented on res_*, waiting for res_rdy
module add_rr_sched #(
    parameter int NREQ = 4,
    parameter int DW = 3,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_vld,
    input  logic [NREQ*DW-1:0]  req_a,
    input  logic [NREQ*DW-1:0]  req_b,
    output logic [NREQ-1:0]     req_rdy,
    output logic                res_vld,
    input  logic                res_rdy,
    output logic [DW:0]         res_sum,
    output logic [IDW-1:0]      res_id,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  grant_id;
    logic            grant_vld;
    logic            accept;
    logic [DW-1:0]   op_a;
    logic [DW-1:0]   op_b;

    // Index base+k folded back into 0..NREQ-1 (NREQ need not be a power of two).
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int k);
        int s;
        s = int'({1'b0, base}) + k;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    // Rotating priority search starting at rr_ptr; first valid requester wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_vld && req_vld[wrap_add(rr_ptr, k)]) begin
                grant_vld = 1'b1;
                grant_id  = wrap_add(rr_ptr, k);
            end
        end
    end

    assign accept  = (state == IDLE) && grant_vld;
    // Grant is gated by rst_n so nothing handshakes while reset is held.
    assign req_rdy = (rst_n && accept) ? (NREQ'(1) << grant_id) : '0;
    assign res_vld = (state == RESP);
    assign busy    = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (res_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture on accept, sum registered in EXEC, pointer advances past the winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            op_a    <= '0;
            op_b    <= '0;
            res_sum <= '0;
            res_id  <= '0;
        end else begin
            if (accept) begin
                op_a   <= req_a[grant_id*DW +: DW];
                op_b   <= req_b[grant_id*DW +: DW];
                res_id <= grant_id;
                rr_ptr <= wrap_add(grant_id, 1);
            end
            if (state == EXEC) begin
                res_sum <= {1'b0, op_a} + {1'b0, op_b};
            end
        end
    end

endmodule

// File: tb/tb_add_rr_sched.sv
// Bench for add_rr_sched: directed scenarios plus random traffic, all checked
// against a transaction-level model (grant search, latency, held result).
module tb_add_rr_sched;
    localparam int NREQ = 4;
    localparam int DW = 3;
    localparam int IDW = $clog2(NREQ);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_vld = '0;
    logic [NREQ*DW-1:0]  req_a = '0;
    logic [NREQ*DW-1:0]  req_b = '0;
    logic [NREQ-1:0]     req_rdy;
    logic                res_vld;
    logic                res_rdy = 1'b1;
    logic [DW:0]         res_sum;
    logic [IDW-1:0]      res_id;
    logic                busy;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    int             m_ptr;
    bit             m_busy;
    int             m_age;
    logic [DW:0]    m_pend;
    logic [DW:0]    m_sum;
    logic [IDW-1:0] m_id;

    // expected outputs for the current cycle
    logic [NREQ-1:0] exp_rdy;
    logic            exp_vld;
    logic            exp_busy;
    logic [DW:0]     exp_sum;
    logic [IDW-1:0]  exp_id;
    int              exp_win;

    add_rr_sched #(.NREQ(NREQ), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_a(req_a), .req_b(req_b),
        .req_rdy(req_rdy), .res_vld(res_vld), .res_rdy(res_rdy),
        .res_sum(res_sum), .res_id(res_id), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int opa(int i);
        return int'(req_a[i*DW +: DW]);
    endfunction

    function automatic int opb(int i);
        return int'(req_b[i*DW +: DW]);
    endfunction

    task automatic set_ops(int i, int a, int b);
        req_a[i*DW +: DW] = DW'(a);
        req_b[i*DW +: DW] = DW'(b);
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) set_ops(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    endtask

    task automatic model_reset();
        m_ptr = 0; m_busy = 0; m_age = 0; m_pend = '0; m_sum = '0; m_id = '0;
    endtask

    // Wait to the falling edge and compute what the DUT should show now.
    task automatic sample();
        @(negedge clk);
        exp_rdy = '0;
        exp_win = -1;
        if (!m_busy && rst_n) begin
            for (int k = 0; k < NREQ; k++) begin
                if (exp_win < 0 && req_vld[(m_ptr + k) % NREQ]) exp_win = (m_ptr + k) % NREQ;
            end
            if (exp_win >= 0) exp_rdy[exp_win] = 1'b1;
        end
        exp_vld  = m_busy && (m_age >= 2);
        exp_busy = m_busy;
        exp_sum  = m_sum;
        exp_id   = m_id;
    endtask

    // Apply one rising edge to the model: accept -> result two cycles later -> release on res_rdy.
    task automatic advance();
        bit acc;
        int win;
        logic [DW:0] s;
        acc = (exp_win >= 0);
        win = exp_win;
        s = '0;
        if (acc) s = (DW+1)'(opa(win) + opb(win));
        @(posedge clk);
        if (m_busy) begin
            if (m_age >= 2) begin
                if (res_rdy) m_busy = 0;
            end else begin
                m_age++;
                if (m_age == 2) m_sum = m_pend;
            end
        end else if (acc) begin
            m_busy = 1; m_age = 1; m_id = IDW'(win);
            m_ptr = (win + 1) % NREQ; m_pend = s;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_vld = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_vld = '1;
        #3;
        n_cmp++; if (req_rdy !== '0)  begin n_bad++; $display("FAIL reset_rdy: got %b want 0", req_rdy); end
        n_cmp++; if (res_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld: got %b want 0", res_vld); end
        n_cmp++; if (res_sum !== '0)  begin n_bad++; $display("FAIL reset_sum: got %0d want 0", res_sum); end
        n_cmp++; if (res_id !== '0)   begin n_bad++; $display("FAIL reset_id: got %0d want 0", res_id); end
        n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        do_reset();
    endtask

    task automatic test_single();
        rand_ops();
        set_ops(2, 5, 6);
        res_rdy = 1'b1;
        req_vld = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            sample();
            n_cmp++; if (req_rdy !== exp_rdy) begin n_bad++; $display("FAIL single_rdy c%0d: got %b want %b", c, req_rdy, exp_rdy); end
            n_cmp++; if (res_vld !== exp_vld) begin n_bad++; $display("FAIL single_vld c%0d: got %b want %b", c, res_vld, exp_vld); end
            n_cmp++; if (busy !== exp_busy)   begin n_bad++; $display("FAIL single_busy c%0d: got %b want %b", c, busy, exp_busy); end
            if (c == 0) begin
                n_cmp++; if (req_rdy !== 4'b0100) begin n_bad++; $display("FAIL single_grant: got %b want 0100", req_rdy); end
            end
            if (c == 2) begin
                n_cmp++; if (res_vld !== 1'b1 || res_sum !== 4'd11 || res_id !== 2'd2)
                    begin n_bad++; $display("FAIL single_result: got v%b s%0d id%0d want v1 s11 id2", res_vld, res_sum, res_id); end
            end
            if (c == 3) begin
                n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle: got busy %b want 0", busy); end
            end
            advance();
            if (c == 0) req_vld = '0;
        end
    endtask

    task automatic test_contention();
        int grants[$];
        int gcyc[$];
        int want[6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        res_rdy = 1'b1;
        req_vld = 4'b1111;
        for (int c = 0; c < 18; c++) begin
            rand_ops();
            sample();
            n_cmp++; if (req_rdy !== exp_rdy) begin n_bad++; $display("FAIL cont_rdy c%0d: got %b want %b", c, req_rdy, exp_rdy); end
            n_cmp++; if (res_vld !== exp_vld || (exp_vld && (res_sum !== exp_sum || res_id !== exp_id)))
                begin n_bad++; $display("FAIL cont_res c%0d: got v%b s%0d id%0d want v%b s%0d id%0d", c, res_vld, res_sum, res_id, exp_vld, exp_sum, exp_id); end
            for (int i = 0; i < NREQ; i++) if (req_rdy[i]) begin grants.push_back(i); gcyc.push_back(c); end
            advance();
        end
        n_cmp++; if (grants.size() != 6) begin n_bad++; $display("FAIL cont_count: got %0d want 6", grants.size()); end
        for (int g = 0; g < 6 && g < grants.size(); g++) begin
            n_cmp++; if (grants[g] != want[g]) begin n_bad++; $display("FAIL cont_order g%0d: got %0d want %0d", g, grants[g], want[g]); end
            n_cmp++; if (gcyc[g] != 3*g) begin n_bad++; $display("FAIL cont_spacing g%0d: got cycle %0d want %0d", g, gcyc[g], 3*g); end
        end
    endtask

    task automatic test_width();
        int sums[2] = '{14, 0};
        int ops[2] = '{7, 0};
        do_reset();
        res_rdy = 1'b1;
        for (int t = 0; t < 2; t++) begin
            set_ops(0, ops[t], ops[t]);
            req_vld = 4'b0001;
            for (int c = 0; c < 3; c++) begin
                sample();
                if (c == 2) begin
                    n_cmp++; if (res_vld !== 1'b1 || res_sum !== (DW+1)'(sums[t]))
                        begin n_bad++; $display("FAIL width_sum t%0d: got v%b s%0d want v1 s%0d", t, res_vld, res_sum, sums[t]); end
                    n_cmp++; if (res_sum !== exp_sum) begin n_bad++; $display("FAIL width_model t%0d: got %0d want %0d", t, res_sum, exp_sum); end
                end
                advance();
                req_vld = '0;
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rand_ops();
        set_ops(0, 3, 4);
        req_vld = 4'b1111;
        res_rdy = 1'b0;
        sample(); advance();
        sample(); advance();
        for (int c = 0; c < 5; c++) begin
            sample();
            n_cmp++; if (res_vld !== 1'b1 || res_sum !== 4'd7 || res_id !== 2'd0)
                begin n_bad++; $display("FAIL bp_hold c%0d: got v%b s%0d id%0d want v1 s7 id0", c, res_vld, res_sum, res_id); end
            n_cmp++; if (req_rdy !== '0) begin n_bad++; $display("FAIL bp_rdy c%0d: got %b want 0", c, req_rdy); end
            advance();
        end
        res_rdy = 1'b1;
        sample();
        n_cmp++; if (res_vld !== exp_vld) begin n_bad++; $display("FAIL bp_release: got %b want %b", res_vld, exp_vld); end
        advance();
        sample();
        n_cmp++; if (busy !== 1'b0 || req_rdy !== 4'b0010)
            begin n_bad++; $display("FAIL bp_next: got busy%b rdy %b want busy0 rdy 0010", busy, req_rdy); end
        advance();
    endtask

    task automatic test_wrap();
        int grants[$];
        int want[4] = '{1, 3, 1, 3};
        do_reset();
        res_rdy = 1'b1;
        req_vld = 4'b1010;
        for (int c = 0; c < 12; c++) begin
            rand_ops();
            sample();
            n_cmp++; if (req_rdy !== exp_rdy) begin n_bad++; $display("FAIL wrap_rdy c%0d: got %b want %b", c, req_rdy, exp_rdy); end
            for (int i = 0; i < NREQ; i++) if (req_rdy[i]) grants.push_back(i);
            advance();
        end
        n_cmp++; if (grants.size() != 4) begin n_bad++; $display("FAIL wrap_count: got %0d want 4", grants.size()); end
        for (int g = 0; g < 4 && g < grants.size(); g++) begin
            n_cmp++; if (grants[g] != want[g]) begin n_bad++; $display("FAIL wrap_order g%0d: got %0d want %0d", g, grants[g], want[g]); end
        end
    endtask

    task automatic test_reset_mid_exec();
        do_reset();
        res_rdy = 1'b1;
        set_ops(1, 6, 5);
        req_vld = 4'b0010;
        for (int c = 0; c < 3; c++) begin sample(); advance(); end
        req_vld = '0;
        sample(); advance();
        set_ops(2, 7, 6);
        req_vld = 4'b0100;
        sample(); advance();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (res_vld !== 1'b0 || res_sum !== '0 || busy !== 1'b0 || res_id !== '0)
            begin n_bad++; $display("FAIL rst_exec: got v%b s%0d id%0d busy%b want all 0", res_vld, res_sum, res_id, busy); end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_vld = 4'b1111;
        for (int c = 0; c < 7; c++) begin
            sample();
            if (c == 0) begin
                n_cmp++; if (req_rdy !== 4'b0001) begin n_bad++; $display("FAIL rst_regrant: got %b want 0001", req_rdy); end
            end
            n_cmp++; if (res_vld !== exp_vld || (exp_vld && (res_sum !== exp_sum || res_id !== exp_id)))
                begin n_bad++; $display("FAIL rst_after c%0d: got v%b s%0d id%0d want v%b s%0d id%0d", c, res_vld, res_sum, res_id, exp_vld, exp_sum, exp_id); end
            n_cmp++; if (c < 3 && res_vld === 1'b1 && res_id === 2'd2)
                begin n_bad++; $display("FAIL rst_ghost c%0d: got aborted result id %0d want none", c, res_id); end
            advance();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_vld = NREQ'($urandom);
            res_rdy = ($urandom_range(0, 9) < 7);
            rand_ops();
            sample();
            n_cmp++; if (req_rdy !== exp_rdy) begin n_bad++; $display("FAIL rand_rdy c%0d: got %b want %b", c, req_rdy, exp_rdy); end
            n_cmp++; if (res_vld !== exp_vld || busy !== exp_busy)
                begin n_bad++; $display("FAIL rand_ctl c%0d: got v%b b%b want v%b b%b", c, res_vld, busy, exp_vld, exp_busy); end
            n_cmp++; if (res_sum !== exp_sum || res_id !== exp_id)
                begin n_bad++; $display("FAIL rand_res c%0d: got s%0d id%0d want s%0d id%0d", c, res_sum, res_id, exp_sum, exp_id); end
            advance();
            // operands change after the handshake and must not disturb the captured pair
            rand_ops();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_width();
        test_backpressure();
        test_wrap();
        test_reset_mid_exec();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
